// File: rtl/enq_pkt_desc_arb.sv
// enq_pkt_desc_arb: round-robin merge of N enqueue descriptor FIFOs into one registered valid/ready stream.
// Weighted round-robin is built when ENQ_PKT_DESC_ARB_WRR_EN is defined; reset port name comes from RESET_SIG.
`ifndef RESET_SIG
`define RESET_SIG rst
`endif
module enq_pkt_desc_arb #(
   parameter int N_PORTS    = 4,
   parameter int PORT_NBITS = 2,
   parameter int DESC_W     = 32
) (
   input  logic                            clk,
   input  logic                            `RESET_SIG,
   input  logic                            arb_en,
   input  logic [N_PORTS-1:0]              fifo_empty,
   input  logic [N_PORTS-1:0][DESC_W-1:0]  fifo_dout,
   output logic [N_PORTS-1:0]              fifo_rd,
   output logic                            enq_valid,
   input  logic                            enq_ready,
   output logic [DESC_W-1:0]               enq_desc,
   output logic [PORT_NBITS-1:0]           enq_port,
   output logic                            busy,
   input  logic [N_PORTS-1:0][3:0]         port_weight
);
   logic [N_PORTS-1:0]    req;
   logic [PORT_NBITS-1:0] rr_ptr, gnt, gnt_nxt, idx;
   logic                  load_ok, grant_v;
   assign req     = ~fifo_empty;
   assign load_ok = ~enq_valid | enq_ready;
   assign grant_v = ~`RESET_SIG & arb_en & load_ok & |req;
   assign fifo_rd = grant_v ? N_PORTS'(1) << gnt : '0;
   assign busy    = enq_valid | |req;
   assign gnt_nxt = (int'(gnt) == N_PORTS - 1) ? '0 : gnt + 1'b1;
   // Scan from the farthest slot back so the first requester at/after rr_ptr wins.
   always_comb begin
      gnt = '0;
      idx = '0;
      for (int k = N_PORTS - 1; k >= 0; k--) begin
         idx = PORT_NBITS'((int'(rr_ptr) + k) % N_PORTS);
         if (req[idx]) gnt = idx;
      end
   end
   always_ff @(posedge clk or posedge `RESET_SIG) begin
      if (`RESET_SIG) begin
         enq_valid <= 1'b0;
         enq_desc  <= '0;
         enq_port  <= '0;
      end else if (grant_v) begin
         enq_valid <= 1'b1;
         enq_desc  <= fifo_dout[gnt];
         enq_port  <= gnt;
      end else if (enq_ready) begin
         enq_valid <= 1'b0;
      end
   end
`ifdef ENQ_PKT_DESC_ARB_WRR_EN
   logic [3:0] burst_cnt, wt;
   assign wt = (port_weight[gnt] == 4'd0) ? 4'd1 : port_weight[gnt];
   // A grant that skips ahead of rr_ptr starts a fresh burst on the granted port.
   always_ff @(posedge clk or posedge `RESET_SIG) begin
      if (`RESET_SIG) begin
         rr_ptr    <= '0;
         burst_cnt <= '0;
      end else if (grant_v) begin
         if (gnt == rr_ptr) begin
            if ({1'b0, burst_cnt} + 5'd1 >= {1'b0, wt}) begin
               rr_ptr    <= gnt_nxt;
               burst_cnt <= '0;
            end else begin
               burst_cnt <= burst_cnt + 4'd1;
            end
         end else if (wt == 4'd1) begin
            rr_ptr    <= gnt_nxt;
            burst_cnt <= '0;
         end else begin
            rr_ptr    <= gnt;
            burst_cnt <= 4'd1;
         end
      end
   end
`else
   logic unused_weight;
   assign unused_weight = ^port_weight;
   always_ff @(posedge clk or posedge `RESET_SIG) begin
      if (`RESET_SIG) rr_ptr <= '0;
      else if (grant_v) rr_ptr <= gnt_nxt;
   end
`endif
endmodule

// File: tb/tb_enq_pkt_desc_arb.sv
// tb_enq_pkt_desc_arb: directed vector table, corner sequences and random traffic against a queue-level model.
module tb_enq_pkt_desc_arb;
   localparam int N = 4;
   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             arb_en = 1'b0, enq_ready = 1'b0;
   logic [N-1:0]     fifo_empty = '1;
   logic [N-1:0][31:0] fifo_dout = '0;
   logic [N-1:0][3:0]  port_weight = '0;
   logic [N-1:0]     fifo_rd;
   logic             enq_valid, busy;
   logic [31:0]      enq_desc;
   logic [1:0]       enq_port;
   int n_cmp = 0, n_bad = 0;
   logic [31:0] mem [N][64];
   int wp [N], rp [N];
   logic        m_valid;
   logic [31:0] m_desc;
   int          m_port, m_ptr, m_burst;
   typedef struct { logic en; logic rdy; logic [3:0] rd; logic v; logic [31:0] desc; logic [1:0] port; } vec_t;
   vec_t tbl [14];

   enq_pkt_desc_arb #(.N_PORTS(N), .PORT_NBITS(2), .DESC_W(32)) dut (
      .clk(clk), .rst(rst), .arb_en(arb_en), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
      .fifo_rd(fifo_rd), .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_desc(enq_desc),
      .enq_port(enq_port), .busy(busy), .port_weight(port_weight));

   always #5 clk = ~clk;

   function automatic logic [31:0] dv(int p, int k);
      return 32'hA000_0000 | 32'(p << 8) | 32'(k);
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic push(input int p, input logic [31:0] d);
      if (wp[p] - rp[p] < 60) begin
         mem[p][wp[p] % 64] = d;
         wp[p]++;
      end
   endtask

   task automatic drive();
      for (int i = 0; i < N; i++) begin
         fifo_empty[i] = (wp[i] == rp[i]);
         fifo_dout[i]  = mem[i][rp[i] % 64];
      end
   endtask

   function automatic logic any_ne();
      for (int i = 0; i < N; i++) if (wp[i] != rp[i]) return 1'b1;
      return 1'b0;
   endfunction

   // Model: the first non-empty queue at or after the turn pointer, circularly.
   function automatic int pick();
      for (int k = 0; k < N; k++) if (wp[(m_ptr + k) % N] != rp[(m_ptr + k) % N]) return (m_ptr + k) % N;
      return -1;
   endfunction

   task automatic cycle(input logic en, input logic rdy);
      int g, w;
      arb_en = en;
      enq_ready = rdy;
      #1;
      g = (en && (!m_valid || rdy)) ? pick() : -1;
      chk("fifo_rd", fifo_rd, (g >= 0) ? 64'(1 << g) : 64'd0);
      chk("enq_valid", enq_valid, m_valid);
      chk("enq_desc", enq_desc, m_desc);
      chk("enq_port", enq_port, m_port);
      chk("busy", busy, m_valid | any_ne());
      @(posedge clk);
      #1;
      if (g >= 0) begin
         m_valid = 1'b1;
         m_desc  = mem[g][rp[g] % 64];
         m_port  = g;
         rp[g]++;
`ifdef ENQ_PKT_DESC_ARB_WRR_EN
         w = (port_weight[g] == 0) ? 1 : int'(port_weight[g]);
         if (g == m_ptr) begin
            if (m_burst + 1 >= w) begin m_ptr = (g + 1) % N; m_burst = 0; end
            else m_burst++;
         end else if (w == 1) begin m_ptr = (g + 1) % N; m_burst = 0; end
         else begin m_ptr = g; m_burst = 1; end
`else
         w = 1;
         m_ptr = (g + w) % N;
`endif
      end else if (rdy) m_valid = 1'b0;
      drive();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      m_valid = 1'b0; m_desc = '0; m_port = 0; m_ptr = 0; m_burst = 0;
      chk("rst_valid", enq_valid, 0);
      chk("rst_desc", enq_desc, 0);
      chk("rst_port", enq_port, 0);
      chk("rst_rd", fifo_rd, 0);
      chk("rst_busy", busy, any_ne());
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < N; i++) begin wp[i] = 0; rp[i] = 0; end
      for (int c = 0; c < 12; c++)
         tbl[c] = '{1'b1, 1'b1, 4'(1 << (c % 4)), (c > 0), (c > 0) ? dv((c - 1) % 4, (c - 1) / 4) : 32'd0,
                    (c > 0) ? 2'((c - 1) % 4) : 2'd0};
      tbl[12] = '{1'b1, 1'b1, 4'b0000, 1'b1, dv(3, 2), 2'd3};
      tbl[13] = '{1'b1, 1'b1, 4'b0000, 1'b0, dv(3, 2), 2'd3};
      port_weight = {4'd1, 4'd1, 4'd1, 4'd1};
      @(negedge clk);
      arb_en = 1'b1;
      enq_ready = 1'b1;
      do_reset();
      // Full-rate rotation over 4 ports x 3 descriptors
      for (int k = 0; k < 3; k++) for (int p = 0; p < N; p++) push(p, dv(p, k));
      drive();
      for (int c = 0; c < 14; c++) begin
         arb_en = tbl[c].en;
         enq_ready = tbl[c].rdy;
         #1;
         chk($sformatf("tbl%0d_rd", c), fifo_rd, tbl[c].rd);
         chk($sformatf("tbl%0d_valid", c), enq_valid, tbl[c].v);
         chk($sformatf("tbl%0d_desc", c), enq_desc, tbl[c].desc);
         chk($sformatf("tbl%0d_port", c), enq_port, tbl[c].port);
         cycle(tbl[c].en, tbl[c].rdy);
      end
      // Single descriptor on port 2
      do_reset();
      push(2, 32'h0000_0A0A);
      drive();
      repeat (3) cycle(1'b1, 1'b1);
      // Five-cycle stall, then grant on the ready cycle
      for (int p = 0; p < N; p++) begin push(p, dv(p, 8)); push(p, dv(p, 9)); end
      drive();
      repeat (2) cycle(1'b1, 1'b1);
      repeat (5) cycle(1'b1, 1'b0);
      repeat (2) cycle(1'b1, 1'b1);
      // Arbitration disabled: held descriptor drains, nothing popped
      repeat (2) cycle(1'b0, 1'b0);
      repeat (2) cycle(1'b0, 1'b1);
      cycle(1'b1, 1'b1);
      // Reset while a descriptor is stalled at the output
      cycle(1'b1, 1'b0);
      do_reset();
      repeat (3) cycle(1'b1, 1'b1);
      // Weighted pattern (port 0 weight 3); plain round-robin in the base build
      do_reset();
      port_weight = {4'd1, 4'd1, 4'd1, 4'd3};
      for (int k = 0; k < 8; k++) for (int p = 0; p < N; p++) push(p, dv(p, 16 + k));
      drive();
      repeat (12) cycle(1'b1, 1'b1);
      // Random traffic
      for (int i = 0; i < N; i++) port_weight[i] = 4'($urandom_range(0, 4));
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 299) == 0) begin
            for (int i = 0; i < N; i++) port_weight[i] = 4'($urandom_range(0, 4));
            do_reset();
         end
         if ($urandom_range(0, 2) == 0) push(int'($urandom_range(0, N - 1)), $urandom);
         if ($urandom_range(0, 3) == 0) push(int'($urandom_range(0, 1)), $urandom);
         drive();
         cycle($urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
